// File: rtl/fsk_decoder.sv
// fsk_decoder: recovers the data bit from a fast/slow FSK carrier by classifying run lengths between input edges
module fsk_decoder #(
  parameter int SHORT_MIN = 2,
  parameter int SHORT_MAX = 3,
  parameter int LONG_MIN  = 12,
  parameter int LONG_MAX  = 20,
  parameter int TIMEOUT   = 24,
  parameter int CNT_W     = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic io_input,
  output logic io_output,
  output logic io_valid,
  output logic io_change
);
  typedef enum logic [1:0] {IDLE, FAST, SLOW} state_t;
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_TO  = CNT_W'(TIMEOUT);
  state_t state_q, state_d;
  logic in_q, primed_q, primed_d, change_q, change_d;
  logic edge_w, fast_w, slow_w, tout_w;
  logic [CNT_W-1:0] run_q, run_d;
  always_comb begin
    edge_w   = io_input != in_q;
    tout_w   = !edge_w && run_q == RUN_TO;
    fast_w   = run_q >= CNT_W'(SHORT_MIN) && run_q <= CNT_W'(SHORT_MAX);
    slow_w   = run_q >= CNT_W'(LONG_MIN) && run_q <= CNT_W'(LONG_MAX);
    run_d    = edge_w ? CNT_W'(1) : run_q == RUN_MAX ? run_q : run_q + CNT_W'(1);
    primed_d = edge_w ? 1'b1 : tout_w ? 1'b0 : primed_q;
    state_d  = state_q;
    if (edge_w && primed_q)
      state_d = fast_w ? FAST : slow_w ? SLOW : state_q;
    else if (tout_w)
      state_d = IDLE;
    change_d = {state_d == FAST, state_d != IDLE} != {state_q == FAST, state_q != IDLE};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q     <= 1'b0;
      run_q    <= '0;
      primed_q <= 1'b0;
      state_q  <= IDLE;
      change_q <= 1'b0;
    end else begin
      in_q     <= io_input;
      run_q    <= run_d;
      primed_q <= primed_d;
      state_q  <= state_d;
      change_q <= change_d;
    end
  end
  assign io_output = state_q == FAST;
  assign io_valid  = state_q != IDLE;
  assign io_change = change_q;
endmodule

// File: tb/tb_fsk_decoder.sv
// tb_fsk_decoder: directed FSK waveforms checked against an edge-timestamp model plus literal expectations
module tb_fsk_decoder;
  logic clock, reset, io_input, io_output, io_valid, io_change;
  logic lvl;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic armed = 1'b0;
  logic m_prev, m_primed, m_chg;
  int m_last, m_cls;
  fsk_decoder dut (
    .clock(clock),
    .reset(reset),
    .io_input(io_input),
    .io_output(io_output),
    .io_valid(io_valid),
    .io_change(io_change)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at cycle %0d", name, got, exp, cyc);
    end
  endtask
  always @(posedge clock) begin
    int d, l, nc;
    logic np;
    cyc <= cyc + 1;
    if (reset) begin
      armed    <= 1'b1;
      m_prev   <= 1'b0;
      m_last   <= cyc + 1;
      m_cls    <= 0;
      m_primed <= 1'b0;
      m_chg    <= 1'b0;
    end else if (armed) begin
      d  = cyc - m_last;
      l  = d > 31 ? 31 : d;
      nc = m_cls;
      np = m_primed;
      if (io_input != m_prev) begin
        if (m_primed)
          nc = (l >= 2 && l <= 3) ? 1 : (l >= 12 && l <= 20) ? 2 : m_cls;
        np = 1'b1;
        m_last <= cyc;
      end else if (d == 24) begin
        nc = 0;
        np = 1'b0;
      end
      m_chg    <= ((nc == 1) != (m_cls == 1)) || ((nc != 0) != (m_cls != 0));
      m_cls    <= nc;
      m_primed <= np;
      m_prev   <= io_input;
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("model_output", io_output, m_cls == 1);
      chk("model_valid", io_valid, m_cls != 0);
      chk("model_change", io_change, m_chg);
    end
  end
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      io_input = v;
      @(posedge clock);
      #1;
    end
  endtask
  task automatic seg(input int n);
    lvl = !lvl;
    hold(lvl, n);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    io_input = 1'b0;
    lvl = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    io_input = 1'b0;
    lvl = 1'b0;
    do_reset();
    chk("reset_valid", io_valid, 1'b0);
    chk("reset_change", io_change, 1'b0);
    hold(1'b0, 30);
    chk("idle_timeout_valid", io_valid, 1'b0);
    chk("idle_timeout_change", io_change, 1'b0);
    do_reset();
    hold(1'b0, 2);
    seg(2);
    chk("prime_discard_valid", io_valid, 1'b0);
    seg(1);
    chk("fast_lock_valid", io_valid, 1'b1);
    chk("fast_lock_output", io_output, 1'b1);
    chk("fast_lock_change", io_change, 1'b1);
    hold(lvl, 1);
    chk("fast_change_once", io_change, 1'b0);
    repeat (6) seg(2);
    seg(7);
    seg(16);
    chk("switch_ambiguous_hold", io_output, 1'b1);
    seg(1);
    chk("switch_slow_output", io_output, 1'b0);
    chk("switch_slow_valid", io_valid, 1'b1);
    chk("switch_slow_change", io_change, 1'b1);
    hold(lvl, 15);
    repeat (5) seg(16);
    chk("slow_steady_output", io_output, 1'b0);
    seg(6);
    seg(1);
    seg(9);
    repeat (3) seg(16);
    chk("glitch_output", io_output, 1'b0);
    chk("glitch_valid", io_valid, 1'b1);
    repeat (4) seg(2);
    chk("pre_freeze_output", io_output, 1'b1);
    hold(lvl, 22);
    chk("freeze_still_valid", io_valid, 1'b1);
    hold(lvl, 1);
    chk("timeout_valid", io_valid, 1'b0);
    chk("timeout_output", io_output, 1'b0);
    chk("timeout_change", io_change, 1'b1);
    seg(2);
    chk("restart_discard_valid", io_valid, 1'b0);
    seg(1);
    chk("restart_valid", io_valid, 1'b1);
    hold(lvl, 1);
    repeat (3) seg(2);
    do_reset();
    chk("midreset_valid", io_valid, 1'b0);
    chk("midreset_output", io_output, 1'b0);
    chk("midreset_change", io_change, 1'b0);
    hold(1'b0, 16);
    repeat (6) seg(16);
    chk("slow_from_reset_valid", io_valid, 1'b1);
    chk("slow_from_reset_output", io_output, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
